// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard transmitter.
// Turns key events into PS/2 scan-code frames: a make event sends key_code, a break event
// sends F0 followed by key_code. Each frame is start(0), data[0..7], odd parity, stop(1).
// Every bit lasts 2*CLK_DIV cycles: ps2_clk high for CLK_DIV, then low for CLK_DIV, with
// ps2_data changing only at the start of a bit. GAP_CYCLES idle-high cycles follow each frame.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   key_code   scan code to send
//   key_break  1 = release (F0 then key_code), 0 = press (key_code)
//   key_valid  event request, accepted when key_ready is high
//   key_ready  block can accept an event (IDLE only)
//   ps2_clk    PS/2 clock line, idle high
//   ps2_data   PS/2 data line, idle high
//   busy       transmission or gap in progress (inverse of key_ready)
//   bytes_sent completed frames, wraps 255->0
module ps2_keyboard_tx #(
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned GAP_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_code,
  input  logic       key_break,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic [7:0] bytes_sent
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e          state_q;
  logic [DivW-1:0] div_cnt_q;
  logic            low_half_q;
  logic [3:0]      bit_idx_q;
  logic [9:0]      shreg_q;     // bits still to send after the start bit, LSB first
  logic [GapW-1:0] gap_cnt_q;
  logic [7:0]      code_q;
  logic            second_q;    // key_code still pending after the F0 frame

  // Data bits, odd parity and stop bit; the start bit is driven directly on load.
  function automatic logic [9:0] frame_tail(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      div_cnt_q  <= '0;
      low_half_q <= 1'b0;
      bit_idx_q  <= 4'd0;
      shreg_q    <= '0;
      gap_cnt_q  <= '0;
      code_q     <= 8'h00;
      second_q   <= 1'b0;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      ps2_clk    <= 1'b1;
      ps2_data   <= 1'b1;
      bytes_sent <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (key_valid) begin
            code_q     <= key_code;
            second_q   <= key_break;
            shreg_q    <= frame_tail(key_break ? 8'hF0 : key_code);
            ps2_data   <= 1'b0;
            ps2_clk    <= 1'b1;
            div_cnt_q  <= '0;
            low_half_q <= 1'b0;
            bit_idx_q  <= 4'd0;
            key_ready  <= 1'b0;
            busy       <= 1'b1;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (div_cnt_q == DivLast) begin
            div_cnt_q <= '0;
            if (!low_half_q) begin
              low_half_q <= 1'b1;
              ps2_clk    <= 1'b0;
            end else begin
              low_half_q <= 1'b0;
              ps2_clk    <= 1'b1;
              if (bit_idx_q == 4'd10) begin
                bytes_sent <= bytes_sent + 8'd1;
                ps2_data   <= 1'b1;
                gap_cnt_q  <= '0;
                state_q    <= StGap;
              end else begin
                bit_idx_q <= bit_idx_q + 4'd1;
                ps2_data  <= shreg_q[0];
                shreg_q   <= {1'b0, shreg_q[9:1]};
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + DivW'(1);
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            if (second_q) begin
              second_q   <= 1'b0;
              shreg_q    <= frame_tail(code_q);
              ps2_data   <= 1'b0;
              div_cnt_q  <= '0;
              low_half_q <= 1'b0;
              bit_idx_q  <= 4'd0;
              state_q    <= StSend;
            end else begin
              key_ready <= 1'b1;
              busy      <= 1'b0;
              state_q   <= StIdle;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Self-checking bench for ps2_keyboard_tx (CLK_DIV=2, GAP_CYCLES=4).
// A line monitor decodes frames at ps2_clk falling edges; the stimulus side keeps the list of
// bytes each event should produce and compares decoded frames, timing and bytes_sent.
`timescale 1ns/1ps
module tb_ps2_keyboard_tx;

  localparam int unsigned ClkDiv = 2;
  localparam int unsigned GapCyc = 4;
  localparam int FrameCyc = 22 * ClkDiv;
  localparam int EventCyc = FrameCyc + GapCyc;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_valid;
  logic       key_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [7:0] bytes_sent;

  ps2_keyboard_tx #(
    .CLK_DIV    (ClkDiv),
    .GAP_CYCLES (GapCyc)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_code   (key_code),
    .key_break  (key_break),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .bytes_sent (bytes_sent)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Whole 11-bit frame as seen on the wire, bit 0 first.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // ---------------- line monitor (written only here) ----------------
  logic [10:0] rx_q[$];
  logic [10:0] fbits;
  int   nbits;
  bit   in_frame;
  logic prev_clk, prev_data, prev_ready;
  int   cyc = 0;
  int   last_start, start_gap;
  int   frames_since_rst;
  int   ready_rises = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      nbits = 0;
      in_frame = 0;
      prev_clk = 1'b1;
      prev_data = 1'b1;
      prev_ready = 1'b1;
      last_start = -1;
      start_gap = -1;
      frames_since_rst = 0;
    end else begin
      if (key_ready && !prev_ready) ready_rises++;
      prev_ready = key_ready;
      if (!in_frame && prev_data && !ps2_data) begin
        in_frame = 1;
        nbits = 0;
        if (last_start >= 0) start_gap = cyc - last_start;
        last_start = cyc;
      end
      if (in_frame && prev_clk && !ps2_clk) begin
        fbits[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          in_frame = 0;
          rx_q.push_back(fbits);
          frames_since_rst++;
        end
      end
      prev_clk = ps2_clk;
      prev_data = ps2_data;
    end
  end

  // ---------------- stimulus side ----------------
  logic [7:0] exp_q[$];
  int rx_chk = 0;

  task automatic check_rx();
    logic [10:0] f;
    while (rx_chk < rx_q.size()) begin
      f = rx_q[rx_chk];
      chk("frame_format", {f[10], f[0], ^f[9:1]}, 3'b101);
      if (rx_chk < exp_q.size()) chk("rx_byte", f[8:1], exp_q[rx_chk]);
      else chk("unexpected_frame", rx_chk, exp_q.size());
      rx_chk++;
    end
  endtask

  task automatic start_event(input logic [7:0] code, input logic brk);
    int t = 0;
    while (!key_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) chk("ready_timeout", t, 0);
    key_code = code;
    key_break = brk;
    key_valid = 1'b1;
    if (brk) exp_q.push_back(8'hF0);
    exp_q.push_back(code);
    @(negedge clk);
    key_valid = 1'b0;
    chk("start_latency", {key_ready, ps2_clk, ps2_data}, 3'b010);
  endtask

  task automatic wait_idle(output int low);
    int bad = 0;
    low = 0;
    while (!key_ready && low < 5000) begin
      low++;
      if (busy === key_ready) bad++;
      @(negedge clk);
    end
    chk("busy_inverse", bad, 0);
  endtask

  task automatic send_event(input logic [7:0] code, input logic brk, output int low);
    start_event(code, brk);
    wait_idle(low);
  endtask

  typedef struct {
    logic [7:0] code;
    logic       brk;
    int         low;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int low, bad, rx_before, n_acc, t, rises_before;

    vecs[0] = '{8'h1C, 1'b0, EventCyc};
    vecs[1] = '{8'h1C, 1'b1, 2 * EventCyc};
    vecs[2] = '{8'hF0, 1'b0, EventCyc};
    vecs[3] = '{8'h00, 1'b0, EventCyc};
    vecs[4] = '{8'hFF, 1'b1, 2 * EventCyc};
    vecs[5] = '{8'h5A, 1'b0, EventCyc};

    rst = 1'b0;
    key_code = 8'h00;
    key_break = 1'b0;
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Idle after reset: everything holds its reset value.
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({ps2_clk, ps2_data, key_ready, busy} !== 4'b1110 || bytes_sent !== 8'h00) bad++;
    end
    chk("idle_hold", bad, 0);
    chk("idle_bytes_sent", bytes_sent, 0);

    // Table-driven events.
    for (int i = 0; i < 6; i++) begin
      rx_before = rx_q.size();
      send_event(vecs[i].code, vecs[i].brk, low);
      chk("busy_length", low, vecs[i].low);
      check_rx();
      chk("bytes_sent", bytes_sent, frames_since_rst % 256);
      if (vecs[i].brk) chk("frame_spacing", start_gap, EventCyc);
      if (i == 0 && rx_q.size() > rx_before) chk("bits_1c", rx_q[rx_before], frame_of(8'h1C));
    end
    chk("bits_1c_literal", rx_q[0], 11'b1_0_00011100_0);

    // key_valid held high with alternating codes.
    rises_before = ready_rises;
    key_code = 8'h15;
    key_break = 1'b0;
    key_valid = 1'b1;
    n_acc = 0;
    t = 0;
    while (n_acc < 4 && t < 2000) begin
      if (key_ready) begin
        exp_q.push_back(key_code);
        n_acc++;
        @(negedge clk);
        key_code = (key_code == 8'h15) ? 8'h24 : 8'h15;
        if (n_acc == 4) key_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
      t++;
    end
    key_valid = 1'b0;
    wait_idle(low);
    check_rx();
    chk("held_spacing", start_gap, EventCyc + 1);
    chk("held_ready_pulses", ready_rises - rises_before, 4);
    chk("held_bytes_sent", bytes_sent, frames_since_rst % 256);

    // Randomized events.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send_event(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), low);
      check_rx();
    end
    chk("rand_bytes_sent", bytes_sent, frames_since_rst % 256);

    // Reset during bit 5 of the F0 frame of a break event.
    rx_before = rx_q.size();
    start_event(8'h1C, 1'b1);
    repeat (2 * ClkDiv * 5) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("rst_lines", {ps2_clk, ps2_data}, 2'b11);
    chk("rst_bytes_sent", bytes_sent, 0);
    chk("rst_ready", {key_ready, busy}, 2'b10);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if ({ps2_clk, ps2_data, key_ready} !== 3'b111) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    chk("post_reset_no_frame", rx_q.size(), rx_before);
    chk("post_reset_bytes_sent", bytes_sent, 0);

    // 256 make events: counter wraps to 0.
    for (int i = 0; i < 256; i++) begin
      send_event(8'($urandom_range(0, 255)), 1'b0, low);
      check_rx();
      if (i == 254) chk("bytes_sent_255", bytes_sent, 255);
    end
    chk("bytes_sent_wrap", bytes_sent, 0);
    chk("wrap_idle", {key_ready, busy, ps2_clk, ps2_data}, 4'b1011);

    check_rx();
    chk("rx_total", rx_q.size(), exp_q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
